// File: rtl/vga_framebuffer_if.sv
// Processor-side framebuffer write port.
// master drives wr_en/wr_addr/wr_data; slave is the framebuffer.
interface vga_framebuffer_if;
  logic        wr_en;
  logic [14:0] wr_addr;
  logic [2:0]  wr_data;

  modport master (
    output wr_en,
    output wr_addr,
    output wr_data
  );

  modport slave (
    input wr_en,
    input wr_addr,
    input wr_data
  );
endinterface

// File: rtl/vga_framebuffer.sv
// Scaled VGA framebuffer: 2-stage read pipeline, write port, frame counter.
// Ports: clk, reset, wr (write bus), pixel_x/y, video_on, hsync_in,
// vsync_in -> rgb, hsync_out, vsync_out, frame_start, frame_count.
module vga_framebuffer #(
  parameter int FB_WIDTH    = 160,
  parameter int FB_HEIGHT   = 120,
  parameter int SCALE_SHIFT = 2
) (
  input  logic                clk,
  input  logic                reset,
  vga_framebuffer_if.slave    wr,
  input  logic [9:0]          pixel_x,
  input  logic [9:0]          pixel_y,
  input  logic                video_on,
  input  logic                hsync_in,
  input  logic                vsync_in,
  output logic [2:0]          rgb,
  output logic                hsync_out,
  output logic                vsync_out,
  output logic                frame_start,
  output logic [15:0]         frame_count
);

  localparam int         DEPTH   = FB_WIDTH * FB_HEIGHT;
  localparam logic [20:0] DEPTH_W = 21'(DEPTH);
  localparam logic [10:0] WBITS   = 11'(FB_WIDTH);

  logic [2:0] mem [DEPTH];

  // Constant-coefficient multiply by FB_WIDTH as a sum of shifts.
  function automatic logic [20:0] mul_w(input logic [9:0] y);
    logic [20:0] acc;
    acc = '0;
    for (int i = 0; i < 11; i++) begin
      if (WBITS[i])
        acc = acc + (21'(y) << i);
    end
    return acc;
  endfunction

  logic [9:0]  xs;
  logic [9:0]  ys;
  logic [20:0] rd_full;
  logic        rd_ok;

  always_comb begin
    xs      = pixel_x >> SCALE_SHIFT;
    ys      = pixel_y >> SCALE_SHIFT;
    rd_full = mul_w(ys) + 21'(xs);
    rd_ok   = rd_full < DEPTH_W;
  end

  // Stage 1
  logic [14:0] rd_addr_q;
  logic        vid1;
  logic        hs1;
  logic        vs1;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_addr_q <= '0;
      vid1      <= 1'b0;
      hs1       <= 1'b1;
      vs1       <= 1'b1;
    end else begin
      rd_addr_q <= rd_ok ? rd_full[14:0] : '0;
      // Out-of-range reads blank the pixel like video_on=0.
      vid1      <= video_on & rd_ok;
      hs1       <= hsync_in;
      vs1       <= vsync_in;
    end
  end

  // Memory: read-first, contents survive reset.
  logic [2:0] ram_q;
  logic       wr_ok;

  assign wr_ok = wr.wr_en && !reset &&
                 (21'(wr.wr_addr) < DEPTH_W);

  always_ff @(posedge clk) begin
    ram_q <= mem[rd_addr_q];
    if (wr_ok)
      mem[wr.wr_addr] <= wr.wr_data;
  end

  // Stage 2
  logic vid2;

  always_ff @(posedge clk) begin
    if (reset) begin
      vid2      <= 1'b0;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
    end else begin
      vid2      <= vid1;
      hsync_out <= hs1;
      vsync_out <= vs1;
    end
  end

  assign rgb = vid2 ? ram_q : 3'b000;

  // Frame edge detect and counter
  logic vs_prev;
  logic vs_fall;

  assign vs_fall = vs_prev & ~vsync_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      vs_prev     <= 1'b1;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      vs_prev     <= vsync_in;
      frame_start <= vs_fall;
      if (vs_fall)
        frame_count <= frame_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_vga_framebuffer.sv
// Directed self-checking bench for vga_framebuffer.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_vga_framebuffer;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        video_on;
  logic        hsync_in;
  logic        vsync_in;
  logic [2:0]  rgb;
  logic        hsync_out;
  logic        vsync_out;
  logic        frame_start;
  logic [15:0] frame_count;

  int checks   = 0;
  int failures = 0;

  vga_framebuffer_if wr_if ();

  vga_framebuffer dut (
    .clk         (clk),
    .reset       (reset),
    .wr          (wr_if.slave),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .video_on    (video_on),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .rgb         (rgb),
    .hsync_out   (hsync_out),
    .vsync_out   (vsync_out),
    .frame_start (frame_start),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr_word(input logic [14:0] a, input logic [2:0] d);
    wr_if.wr_en   = 1'b1;
    wr_if.wr_addr = a;
    wr_if.wr_data = d;
    step(1);
    wr_if.wr_en   = 1'b0;
  endtask

  task automatic drive(input int x, input int y, input logic v);
    pixel_x  = 10'(x);
    pixel_y  = 10'(y);
    video_on = v;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    step(2);
    checks++;
    if (rgb !== 3'b000) begin
      failures++;
      $display("FAIL reset_rgb got=%0h exp=0", rgb);
    end
    checks++;
    if (hsync_out !== 1'b1 || vsync_out !== 1'b1) begin
      failures++;
      $display("FAIL reset_sync got=%b%b exp=11", hsync_out, vsync_out);
    end
    checks++;
    if (frame_start !== 1'b0 || frame_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_frame got=%b/%0h exp=0/0",
               frame_start, frame_count);
    end
    reset = 1'b0;
    step(1);
  endtask

  task automatic test_scale;
    wr_word(15'd0, 3'b101);
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 4; x++) begin
        drive(x, y, 1'b1);
        step(2);
        checks++;
        if (rgb !== 3'b101) begin
          failures++;
          $display("FAIL scale x=%0d y=%0d got=%0h exp=5", x, y, rgb);
        end
      end
    end
  endtask

  task automatic test_addr;
    wr_word(15'd160, 3'b110);
    wr_word(15'd161, 3'b010);
    wr_word(15'd19199, 3'b111);
    drive(4, 4, 1'b1);
    step(2);
    checks++;
    if (rgb !== 3'b010) begin
      failures++;
      $display("FAIL addr161 got=%0h exp=2", rgb);
    end
    drive(3, 4, 1'b1);
    step(2);
    checks++;
    if (rgb !== 3'b110) begin
      failures++;
      $display("FAIL addr160 got=%0h exp=6", rgb);
    end
    drive(639, 479, 1'b1);
    step(2);
    checks++;
    if (rgb !== 3'b111) begin
      failures++;
      $display("FAIL addr_last got=%0h exp=7", rgb);
    end
    drive(0, 480, 1'b1);
    step(2);
    checks++;
    if (rgb !== 3'b000) begin
      failures++;
      $display("FAIL addr_oob_read got=%0h exp=0", rgb);
    end
  endtask

  task automatic test_video_off;
    drive(4, 4, 1'b0);
    step(2);
    checks++;
    if (rgb !== 3'b000) begin
      failures++;
      $display("FAIL video_off got=%0h exp=0", rgb);
    end
    hsync_in = 1'b0;
    step(1);
    checks++;
    if (hsync_out !== 1'b1) begin
      failures++;
      $display("FAIL hsync_n1 got=%b exp=1", hsync_out);
    end
    hsync_in = 1'b1;
    step(1);
    checks++;
    if (hsync_out !== 1'b0) begin
      failures++;
      $display("FAIL hsync_n2 got=%b exp=0", hsync_out);
    end
    step(1);
    checks++;
    if (hsync_out !== 1'b1) begin
      failures++;
      $display("FAIL hsync_n3 got=%b exp=1", hsync_out);
    end
  endtask

  task automatic test_same_cycle;
    wr_word(15'd5, 3'b011);
    drive(20, 0, 1'b1);
    step(1);
    wr_if.wr_en   = 1'b1;
    wr_if.wr_addr = 15'd5;
    wr_if.wr_data = 3'b100;
    step(1);
    wr_if.wr_en   = 1'b0;
    checks++;
    if (rgb !== 3'b011) begin
      failures++;
      $display("FAIL read_first_old got=%0h exp=3", rgb);
    end
    step(1);
    checks++;
    if (rgb !== 3'b100) begin
      failures++;
      $display("FAIL read_first_new got=%0h exp=4", rgb);
    end
  endtask

  task automatic test_oob_write;
    wr_word(15'd19200, 3'b111);
    wr_word(15'h7fff, 3'b111);
    drive(0, 0, 1'b1);
    step(2);
    checks++;
    if (rgb !== 3'b101) begin
      failures++;
      $display("FAIL oob_wr_addr0 got=%0h exp=5", rgb);
    end
    drive(20, 0, 1'b1);
    step(2);
    checks++;
    if (rgb !== 3'b100) begin
      failures++;
      $display("FAIL oob_wr_addr5 got=%0h exp=4", rgb);
    end
  endtask

  task automatic test_frames;
    int pulses;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      vsync_in = 1'b0;
      for (int c = 0; c < 6; c++) begin
        step(1);
        if (frame_start === 1'b1)
          pulses++;
        if (c == 0) begin
          checks++;
          if (frame_start !== 1'b1 || vsync_out !== 1'b1) begin
            failures++;
            $display("FAIL frame%0d_c0 got=%b/%b exp=1/1",
                     i, frame_start, vsync_out);
          end
        end
        if (c == 1) begin
          checks++;
          if (frame_start !== 1'b0 || vsync_out !== 1'b0) begin
            failures++;
            $display("FAIL frame%0d_c1 got=%b/%b exp=0/0",
                     i, frame_start, vsync_out);
          end
        end
      end
      vsync_in = 1'b1;
      for (int c = 0; c < 4; c++) begin
        step(1);
        if (frame_start === 1'b1)
          pulses++;
      end
    end
    checks++;
    if (pulses != 3) begin
      failures++;
      $display("FAIL frame_pulses got=%0d exp=3", pulses);
    end
    checks++;
    if (frame_count !== 16'd3) begin
      failures++;
      $display("FAIL frame_count got=%0h exp=3", frame_count);
    end
  endtask

  task automatic test_reset_mid;
    drive(4, 4, 1'b1);
    hsync_in = 1'b0;
    step(2);
    checks++;
    if (rgb !== 3'b010 || hsync_out !== 1'b0) begin
      failures++;
      $display("FAIL pre_reset got=%0h/%b exp=2/0", rgb, hsync_out);
    end
    reset         = 1'b1;
    wr_if.wr_en   = 1'b1;
    wr_if.wr_addr = 15'd161;
    wr_if.wr_data = 3'b111;
    step(1);
    reset       = 1'b0;
    wr_if.wr_en = 1'b0;
    checks++;
    if (rgb !== 3'b000 || hsync_out !== 1'b1 || vsync_out !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset got=%0h/%b/%b exp=0/1/1",
               rgb, hsync_out, vsync_out);
    end
    checks++;
    if (frame_count !== 16'd0 || frame_start !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_frame got=%0h/%b exp=0/0",
               frame_count, frame_start);
    end
    step(1);
    checks++;
    if (rgb !== 3'b000 || hsync_out !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_1 got=%0h/%b exp=0/1", rgb, hsync_out);
    end
    step(1);
    checks++;
    if (rgb !== 3'b010 || hsync_out !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_2 got=%0h/%b exp=2/0", rgb, hsync_out);
    end
    checks++;
    if (frame_start !== 1'b0 || frame_count !== 16'd0) begin
      failures++;
      $display("FAIL post_reset_frame got=%b/%0h exp=0/0",
               frame_start, frame_count);
    end
    hsync_in = 1'b1;
    step(2);
  endtask

  task automatic test_wrap;
    force dut.frame_count = 16'hffff;
    #1;
    release dut.frame_count;
    vsync_in = 1'b0;
    step(1);
    checks++;
    if (frame_start !== 1'b1 || frame_count !== 16'd0) begin
      failures++;
      $display("FAIL wrap got=%b/%0h exp=1/0", frame_start, frame_count);
    end
    vsync_in = 1'b1;
    step(3);
  endtask

  initial begin
    reset         = 1'b1;
    wr_if.wr_en   = 1'b0;
    wr_if.wr_addr = '0;
    wr_if.wr_data = '0;
    pixel_x       = '0;
    pixel_y       = '0;
    video_on      = 1'b0;
    hsync_in      = 1'b1;
    vsync_in      = 1'b1;
    step(1);
    test_reset;
    test_scale;
    test_addr;
    test_video_off;
    test_same_cycle;
    test_oob_write;
    test_frames;
    test_reset_mid;
    test_wrap;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_framebuffer.md
VGA_FRAMEBUFFER -- requirements
Module: vga_framebuffer

Interface
REQ-001 Parameter FB_WIDTH, default 160, SHALL set the framebuffer columns (pixels).
REQ-002 Parameter FB_HEIGHT, default 120, SHALL set the framebuffer rows (pixels).
REQ-003 Parameter SCALE_SHIFT, default 2, SHALL set log2 of the screen-pixel-to-framebuffer-pixel scale factor.
REQ-004 Port clk, input, 1 bit, SHALL be the 25 MHz pixel clock; all logic SHALL run on its rising edge.
REQ-005 Port reset, input, 1 bit, SHALL be a synchronous, active-high reset.
REQ-006 Port pixel_x, input, 10 bits, SHALL carry the current screen X coordinate from the timing generator.
REQ-007 Port pixel_y, input, 10 bits, SHALL carry the current screen Y coordinate.
REQ-008 Port video_on, input, 1 bit, SHALL be high when the coordinates are in the visible area.
REQ-009 Port hsync_in, input, 1 bit, SHALL be the active-low horizontal sync from the timing generator.
REQ-010 Port vsync_in, input, 1 bit, SHALL be the active-low vertical sync from the timing generator.
REQ-011 Port wr_en, input, 1 bit, SHALL be the processor framebuffer write strobe.
REQ-012 Port wr_addr, input, 15 bits, SHALL be the linear framebuffer write address, y*FB_WIDTH+x.
REQ-013 Port wr_data, input, 3 bits, SHALL be the RGB write value.
REQ-014 Port rgb, output, 3 bits, SHALL be the pixel colour to the DAC.
REQ-015 Port hsync_out, output, 1 bit, SHALL be hsync_in delayed to align with rgb.
REQ-016 Port vsync_out, output, 1 bit, SHALL be vsync_in delayed to align with rgb.
REQ-017 Port frame_start, output, 1 bit, SHALL be a one-cycle pulse marking the start of each frame.
REQ-018 Port frame_count, output, 16 bits, SHALL count frames since reset.

Function
REQ-019 Storage SHALL be FB_WIDTH*FB_HEIGHT words of 3 bits (19200 at defaults), with a synchronous read port and a synchronous write port.
REQ-020 Write: if wr_en=1 and wr_addr<FB_WIDTH*FB_HEIGHT, the word SHALL update at that edge; if wr_addr>=FB_WIDTH*FB_HEIGHT, the write SHALL be ignored.
REQ-021 Read address SHALL be (pixel_y>>SCALE_SHIFT)*FB_WIDTH+(pixel_x>>SCALE_SHIFT), computed using shifts and adds only (y*128+y*32 at defaults), with no multiplier.
REQ-022 Pipeline stage 1 SHALL register the read address, video_on, hsync_in and vsync_in.
REQ-023 Pipeline stage 2 SHALL register the RAM data, the delayed controls and rgb.
REQ-024 Total latency from inputs to rgb, hsync_out and vsync_out SHALL be exactly 2 clk cycles.
REQ-025 rgb SHALL equal the RAM data when the 2-cycle-delayed video_on is 1, and 3'b000 otherwise.
REQ-026 If the computed read address is >= FB_WIDTH*FB_HEIGHT, rgb SHALL be 3'b000.
REQ-027 On a read and a write to the same address in the same cycle, the read SHALL return the old data (read-first); the new data SHALL be visible from the next read.
REQ-028 Frame-edge detection SHALL register vsync_in; a 1->0 transition SHALL assert frame_start for exactly one cycle, on the cycle after the first low sample.
REQ-029 frame_count SHALL increment in the same cycle that frame_start is asserted, and SHALL wrap from 16'hFFFF to 0.
REQ-030 The read path and the write path SHALL be independent, with no stalls and no backpressure.

Reset
REQ-031 While reset=1 at an edge, the following SHALL hold:
- rgb = 0;
- hsync_out = 1 and vsync_out = 1;
- frame_start = 0 and frame_count = 0;
- all pipeline control registers SHALL clear to video_on=0, hsync=1, vsync=1;
- the registered previous vsync SHALL be 1.
REQ-032 Framebuffer contents SHALL NOT be cleared by reset; writes with wr_en=1 during reset SHALL be ignored.
REQ-033 After a reset asserted mid-frame is released, outputs SHALL track the inputs with 2-cycle latency from the first post-reset cycle. No frame_start SHALL occur until a genuine vsync_in falling edge.

Verification
REQ-034 Write addr 0=3'b101, then drive pixel_x=0..3, pixel_y=0..3 with video_on=1 -> rgb=3'b101 two cycles later for all 16 coordinates.
REQ-035 Write addr 161=3'b010; drive (x=4,y=4) -> rgb=3'b010 after 2 cycles; drive (x=3,y=4) -> rgb shows addr 160 data.
REQ-036 Drive video_on=0 with nonzero RAM data -> rgb=0; toggle hsync_in on cycle N -> hsync_out toggles on cycle N+2.
REQ-037 Drive wr_addr=19200 with wr_en=1 -> no RAM word changes; a same-cycle read and write to addr 5 returns the old value, and the next read returns the new value.
REQ-038 Run 3 vsync_in falling edges -> exactly 3 single-cycle frame_start pulses and frame_count=3; preload frame_count to 16'hFFFF via forced stimulus -> the next edge gives 0.
REQ-039 Assert reset for 1 cycle mid-line -> next-edge outputs rgb=0, hsync_out=1, vsync_out=1, frame_count=0, RAM data intact.
